// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared constants and helpers for CPU pipeline registers
package cpu_pipe_pkg;

  localparam int PIPE_MODE_GLOBAL   = 0;
  localparam int PIPE_MODE_COLLAPSE = 1;

  // Width of an occupancy counter able to hold 0..stages inclusive
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// rtl/pipe_stage_slot.sv - one valid+payload register slot of a pipeline register
module pipe_stage_slot
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FLUSH_ZERO = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Flush beats load; a slot without enable keeps its contents
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      if (FLUSH_ZERO != 0) begin
        r_data <= '0;
      end
    end else if (en_i) begin
      r_valid <= valid_i;
      r_data  <= data_i;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised multi-stage pipeline register with stall, flush and bubble collapse
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int STAGES     = 1,
  parameter int COLLAPSE   = 0,
  parameter int FLUSH_ZERO = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         stall_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [DATA_W-1:0]            data_o,
  output logic [occ_width(STAGES)-1:0] occ_o
);

  localparam int OCC_W = occ_width(STAGES);

  if (STAGES < 1 || DATA_W < 1) begin : g_bad_params
    $error("pipe_stage_reg: STAGES and DATA_W must both be >= 1");
  end

  logic [STAGES-1:0] w_v;
  logic [DATA_W-1:0] w_d    [STAGES];
  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_ld_v;
  logic [DATA_W-1:0] w_ld_d [STAGES];
  logic              w_chain;
  logic [OCC_W-1:0]  w_occ;

  // Each slot loads from its upstream neighbour; slot 0 loads from the input port
  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    if (k == 0) begin : g_first
      assign w_ld_v[k] = valid_i;
      assign w_ld_d[k] = data_i;
    end else begin : g_rest
      assign w_ld_v[k] = w_v[k-1];
      assign w_ld_d[k] = w_d[k-1];
    end

    pipe_stage_slot #(
      .DATA_W     (DATA_W),
      .FLUSH_ZERO (FLUSH_ZERO)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (w_en[k]),
      .flush_i (flush_i),
      .valid_i (w_ld_v[k]),
      .data_i  (w_ld_d[k]),
      .valid_o (w_v[k]),
      .data_o  (w_d[k])
    );
  end

  // Stage enables: global stall, or a chain walking back from the output where empty slots always load
  always_comb begin
    w_en    = '0;
    w_chain = 1'b0;
    if (COLLAPSE == PIPE_MODE_COLLAPSE) begin
      w_chain          = !stall_i || !w_v[STAGES-1];
      w_en[STAGES-1]   = w_chain;
      for (int k = STAGES - 2; k >= 0; k--) begin
        w_chain = !w_v[k] || w_chain;
        w_en[k] = w_chain;
      end
    end else begin
      w_en = {STAGES{!stall_i}};
    end
  end

  // Occupancy is a popcount of the valid bits, so it can never exceed STAGES
  always_comb begin
    w_occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_occ = w_occ + OCC_W'(w_v[k]);
    end
  end

  assign ready_o = w_en[0];
  assign valid_o = w_v[STAGES-1];
  assign data_o  = w_d[STAGES-1];
  assign occ_o   = w_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        g_valid, g_stall, g_flush;
  logic [31:0] g_data;
  logic        g_ready, g_vo;
  logic [31:0] g_do;
  logic [1:0]  g_occ;

  logic        n_ready, n_vo;
  logic [31:0] n_do;
  logic [1:0]  n_occ;

  logic        c_valid, c_stall, c_flush;
  logic [31:0] c_data;
  logic        c_ready, c_vo;
  logic [31:0] c_do;
  logic [1:0]  c_occ;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .STAGES(3), .COLLAPSE(0), .FLUSH_ZERO(1)) u_glob (
    .clk_i(clk), .rst_i(rst_n), .valid_i(g_valid), .data_i(g_data),
    .stall_i(g_stall), .flush_i(g_flush), .ready_o(g_ready),
    .valid_o(g_vo), .data_o(g_do), .occ_o(g_occ));

  pipe_stage_reg #(.DATA_W(32), .STAGES(3), .COLLAPSE(0), .FLUSH_ZERO(0)) u_nozero (
    .clk_i(clk), .rst_i(rst_n), .valid_i(g_valid), .data_i(g_data),
    .stall_i(g_stall), .flush_i(g_flush), .ready_o(n_ready),
    .valid_o(n_vo), .data_o(n_do), .occ_o(n_occ));

  pipe_stage_reg #(.DATA_W(32), .STAGES(3), .COLLAPSE(1), .FLUSH_ZERO(1)) u_coll (
    .clk_i(clk), .rst_i(rst_n), .valid_i(c_valid), .data_i(c_data),
    .stall_i(c_stall), .flush_i(c_flush), .ready_o(c_ready),
    .valid_o(c_vo), .data_o(c_do), .occ_o(c_occ));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        stall;
    logic        flush;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_occ;
    logic [31:0] e_data_nz;
  } vec_t;

  vec_t vt [15];

  task automatic cstep(input logic v, input logic [31:0] d, input logic s,
                       input logic e_rdy_pre, input logic e_vo, input logic [31:0] e_do,
                       input logic [1:0] e_occ, input string tag);
    @(negedge clk);
    c_valid = v; c_data = d; c_stall = s; c_flush = 1'b0;
    #1 chk({tag, ".ready_pre"}, 32'(c_ready), 32'(e_rdy_pre));
    @(posedge clk);
    #1;
    chk({tag, ".valid_o"}, 32'(c_vo), 32'(e_vo));
    chk({tag, ".data_o"}, c_do, e_do);
    chk({tag, ".occ_o"}, 32'(c_occ), 32'(e_occ));
  endtask

  initial begin
    //            valid  data      stall flush rdy  vo   data_o    occ  data_o(no-zero)
    vt[0]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd1, 32'h0};
    vt[1]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd2, 32'h0};
    vt[2]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 2'd3, 32'hA};
    vt[3]  = '{1'b1, 32'hD,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 2'd3, 32'hA};
    vt[4]  = '{1'b1, 32'hD,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 2'd3, 32'hA};
    vt[5]  = '{1'b1, 32'hD,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 2'd3, 32'hA};
    vt[6]  = '{1'b1, 32'hD,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 2'd3, 32'hA};
    vt[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'hB, 2'd2, 32'hB};
    vt[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'hC, 2'd1, 32'hC};
    vt[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 32'h0};
    vt[10] = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd1, 32'h0};
    vt[11] = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd2, 32'h0};
    vt[12] = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 2'd3, 32'hA};
    vt[13] = '{1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'hA};
    vt[14] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 32'hB};

    rst_n   = 1'b0;
    g_valid = 1'b1; g_data = 32'hDEAD; g_stall = 1'b0; g_flush = 1'b0;
    c_valid = 1'b1; c_data = 32'hDEAD; c_stall = 1'b0; c_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid_o", 32'(g_vo), 32'h0);
    chk("rst.data_o", g_do, 32'h0);
    chk("rst.occ_o", 32'(g_occ), 32'h0);
    chk("rst.coll_valid_o", 32'(c_vo), 32'h0);
    chk("rst.coll_data_o", c_do, 32'h0);
    chk("rst.coll_occ_o", 32'(c_occ), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    g_valid = 1'b0; g_data = 32'h0;
    c_valid = 1'b0; c_data = 32'h0;
    #1;
    chk("rel.ready_o", 32'(g_ready), 32'h1);
    chk("rel.coll_ready_o", 32'(c_ready), 32'h1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      g_valid = vt[i].valid; g_data = vt[i].data;
      g_stall = vt[i].stall; g_flush = vt[i].flush;
      #1;
      chk($sformatf("vec%0d.ready_o", i), 32'(g_ready), 32'(vt[i].e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.valid_o", i), 32'(g_vo), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d.data_o", i), g_do, vt[i].e_data);
      chk($sformatf("vec%0d.occ_o", i), 32'(g_occ), 32'(vt[i].e_occ));
      chk($sformatf("vec%0d.nz_valid_o", i), 32'(n_vo), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d.nz_data_o", i), n_do, vt[i].e_data_nz);
    end

    // Bubble collapse: 0x11, bubble, 0x22, then stall with 0x11 at the output
    cstep(1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h0,  2'd1, "col1");
    cstep(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  2'd1, "col2");
    cstep(1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h11, 2'd2, "col3");
    cstep(1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h11, 2'd2, "col4");
    chk("col4.ready_post", 32'(c_ready), 32'h1);
    cstep(1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h11, 2'd3, "col5");
    chk("col5.ready_full", 32'(c_ready), 32'h0);
    cstep(1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 32'h11, 2'd3, "col6");
    cstep(1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h22, 2'd2, "col7");
    cstep(1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h33, 2'd1, "col8");
    cstep(1'b1, 32'h66, 1'b1, 1'b1, 1'b1, 32'h33, 2'd2, "col9");

    // Asynchronous reset between edges while two stages are occupied
    @(negedge clk);
    c_valid = 1'b0; c_stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid_o", 32'(c_vo), 32'h0);
    chk("arst.data_o", c_do, 32'h0);
    chk("arst.occ_o", 32'(c_occ), 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised multi-stage pipeline register with per-stage valid bits, stall (hold) and flush (bubble insertion). It generalises the fixed IF/ID latch into a reusable block.
- Width, depth and stall mode are parameters. Optional bubble-collapsing lets upstream stages advance into empty slots while the output is stalled.
- Instantiated between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32, payload width in bits (pc+4, instruction, control fields packed by the caller).
- STAGES, 1, number of register stages, i.e. latency; must be >= 1.
- COLLAPSE, 0, 0 = global stall holds every stage; 1 = stall holds only blocked stages, and bubbles are squeezed out.
- FLUSH_ZERO, 1, 1 = flush zeroes payloads as well as valids; 0 = flush clears valids only.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- valid_i  input  1  upstream payload valid.
- data_i  input  DATA_W  upstream payload.
- stall_i  input  1  downstream cannot take the output this cycle.
- flush_i  input  1  squash all stages.
- ready_o  output  1  stage 0 accepts data_i at the next edge.
- valid_o  output  1  valid bit of the last stage.
- data_o  output  DATA_W  payload of the last stage.
- occ_o  output  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- State: v[k], d[k] for k = 0..STAGES-1; stage STAGES-1 drives valid_o/data_o directly (registered outputs, no combinational path from inputs).
- Reset (rst_i=0, asynchronous, any time, including mid-stream): all v=0, all d=0, so valid_o=0, data_o=0, occ_o=0. ready_o follows its combinational rule once reset releases.
- Priority at each edge: reset > flush > stall/advance.
- Flush: all v <= 0. If FLUSH_ZERO=1, all d <= 0, else d holds.
  - A valid_i on the same edge is discarded.
  - Flush overrides stall_i.
  - ready_o is not gated by flush_i.
- COLLAPSE=0:
  - en_k = !stall_i for all k; ready_o = !stall_i.
  - If en: v[0]<=valid_i, d[0]<=data_i; v[k]<=v[k-1], d[k]<=d[k-1]. Otherwise all hold.
  - Latency: data accepted at edge n appears on data_o after edge n+STAGES-1, i.e. visible STAGES cycles after presentation.
- COLLAPSE=1:
  - en_last = !stall_i || !v[last].
  - en_k = !v[k] || en_{k+1} (combinational chain from the output back).
  - ready_o = en_0.
  - A stage with en_k loads from k-1 (stage 0 from valid_i/data_i); a stage without en_k holds.
  - An invalid stage always loads, so bubbles fill whenever an upstream stage holds valid data.
- valid_i while ready_o=0: not captured. Upstream must hold valid_i/data_i until ready_o=1.
- Payload of invalid stages is don't-care downstream but must still follow the load rule: deterministic, zero after reset or flush with FLUSH_ZERO=1.
- occ_o = popcount(v), registered-equivalent (derived only from v). Range 0..STAGES; never wraps.
- STAGES=1, COLLAPSE=0 reproduces a plain stall/flush latch. With FLUSH_ZERO=1, flushed payload is 0 (a NOP encoding).
- Full pipe with stall_i=1 (COLLAPSE=1): ready_o=0 and occ_o=STAGES.
- Empty pipe with stall_i=1 (COLLAPSE=1): ready_o=1, and data fills up to the last stage.
- Elaboration error if STAGES < 1 or DATA_W < 1.

Decomposition:
- Shared package cpu_pipe_pkg:
  - localparams PIPE_MODE_GLOBAL=0 and PIPE_MODE_COLLAPSE=1.
  - Function for occupancy width (clog2(STAGES+1)).
- Sub-module pipe_stage_slot: one valid+payload register with en, flush, load inputs and async active-low reset.
  - Instantiated STAGES times in a generate loop.
  - Top level computes the en chain, ready_o and occ_o.

Test Plan (DATA_W=32, STAGES=3, FLUSH_ZERO=1 unless noted):
- Reset: hold rst_i=0 for 2 cycles with valid_i=1, data_i=0xDEAD -> valid_o=0, data_o=0, occ_o=0. Release -> ready_o=1.
- Streaming (COLLAPSE=0): present 0xA, 0xB, 0xC on consecutive cycles, stall_i=0 -> data_o=0xA with valid_o=1 three cycles after 0xA is presented, then 0xB, then 0xC; occ_o peaks at 3.
- Global stall (COLLAPSE=0): pipe full (0xA..0xC), stall_i=1 for 4 cycles -> ready_o=0, outputs frozen at 0xA, occ_o=3. Release -> 0xB next cycle.
- Collapse (COLLAPSE=1): push 0x11, one bubble, then 0x22; set stall_i=1 when 0x11 reaches the output -> 0x22 advances into stage 1 the next cycle, occ_o=2, ready_o=1. After 0x33 is accepted -> occ_o=3, ready_o=0.
- Flush vs stall: full pipe, stall_i=1, flush_i=1 together with valid_i=1, data_i=0x44 -> next edge valid_o=0, data_o=0, occ_o=0, and 0x44 is not captured. With FLUSH_ZERO=0, data_o is unchanged.
- Async reset mid-stream: assert rst_i=0 between clock edges while occ_o=2 -> valid_o and occ_o go to 0 immediately, without waiting for a clock edge.
